seg_scan_capture: RTL and testbench
===================================

// Module: seg_scan_capture
// PURPOSE
//  Receive end of the 4-digit multiplexed 7-segment bus (digit strobe SA, segment byte L).
//  Watches strobes, latches each digit's segment byte and decodes it back to hex.
//  Reports frame completion, multi-frame stability and loss of scan.
//  Used for display readback in self-test and as a bus monitor in benches.
// PARAMETERS
//  STABLE_FRAMES  3     identical consecutive frames required before STABLE=1 (>=1)
//  TIMEOUT        1024  clocks without a new strobe before LOST=1 (>=2)
// PORTS
//  CLK          in   1   system clock, all logic on posedge
//  RESET        in   1   asynchronous, active-high reset
//  SA           in   4   digit strobe, one-hot active-high; 1000=D4, 0100=D3, 0010=D2, 0001=D1; 0000=blank gap
//  L            in   8   segment byte {a,b,c,d,e,f,g,dp}, active-high lit; valid whenever SA!=0
//  D1..D4       out  8   raw captured segment byte per digit
//  HEX1..HEX4   out  4   decoded hex value per digit (0 when not decodable)
//  DIGIT_OK     out  4   bit n-1: HEXn decoded from a legal glyph
//  FRAME        out  1   one-cycle pulse, all four digits captured since last FRAME
//  STABLE       out  1   last STABLE_FRAMES frames had identical D1..D4
//  ERR          out  1   one-cycle pulse, SA had more than one bit set
//  LOST         out  1   no strobe start for TIMEOUT clocks
// BEHAVIOUR
//  Reset: D*=0, HEX*=0, DIGIT_OK=0, FRAME=0, STABLE=0, ERR=0, LOST=1, seen mask=0, stable count=0, timeout count=0.
//  SA_q holds SA from the previous edge; SA_q resets to 0000.
//  Strobe start: SA one-hot and SA!=SA_q. At that edge:
//    - Dn<=L, HEXn/DIGIT_OK[n-1] from the decode of L[7:1] (dp ignored).
//    - Seen bit n is set, timeout count goes to 0, LOST<=0.
//  A strobe held for several cycles captures once, on its first cycle.
//  A re-strobe of the same digit after a gap overwrites it; this is not an error.
//  SA=0000 (gap): no capture; the timeout counter increments.
//  SA with >1 bit set: ERR pulses one cycle, no capture, seen mask unchanged, SA_q still updated.
//  Frame completion, when a strobe start makes seen mask 1111:
//    - FRAME=1 for the next cycle only; seen mask clears at the same edge.
//    - Snapshot of {D4..D1} is compared with the previous frame snapshot (reset snapshot=0).
//    - Equal: stable count increments, saturating at STABLE_FRAMES. Differ: count goes to 1.
//    - STABLE=1 iff count==STABLE_FRAMES. It updates with FRAME, so STABLE_FRAMES=1 means STABLE after the first frame.
//  Timeout: counter reaches TIMEOUT-1 with no strobe start -> next edge LOST=1, STABLE=0, count=0, seen mask=0.
//    - Counter saturates. D*/HEX* keep their last values.
//  Latency: outputs visible in the cycle after the sampling edge. FRAME follows the 4th capture by 1 cycle.
//  Legal glyph table (L[7:1]<<1): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=EE b=3E C=9C d=7A E=9E F=8E.
//  Any other pattern: HEXn=0, DIGIT_OK[n-1]=0 (blank 00 is not OK).
//  RESET asserted mid-frame: everything returns to reset values at once; the partial frame is discarded.
// CONFIGURATION
//  SEG_CAPTURE_SYNC_EN defined:
//    - SA and L pass through a 2-flop synchroniser before SA_q/edge logic.
//    - All latencies +2 clocks. Synchroniser flops reset to 0.
//  Not defined: SA/L are used directly; they must be synchronous to CLK.
// STRUCTURE
//  Shared package: the 16-entry glyph table constants, SA digit one-hot constants, and the segment bit-order localparams.
//  The glyph table and constants are shared with the display driver.
//  One sub-module: seg7_decode (comb, L[7:1] -> {ok,hex[3:0]}), instanced once on the live L byte.
//  Top holds the SA_q edge detect, seen mask, snapshot/compare, stable and timeout counters.
// TESTING
//  Drive SA 1000/0000/0100/0000/0010/0000/0001/0000 with L=60,DA,F2,66 -> D4..D1=60,DA,F2,66; HEX4..1=1,2,3,4.
//    DIGIT_OK=1111, FRAME one pulse after the 0001 capture, LOST 1->0 on first strobe.
//  Repeat that frame 3 times -> STABLE=1 with 3rd FRAME; 4th frame D1 L=B6 -> STABLE=0, HEX1=5.
//  SA=0101 one cycle -> ERR pulse, D*/seen unchanged; SA held 0010 for 5 cycles with L changing -> only first L captured.
//  L=0x01 or 0x00 on a strobe -> HEXn=0, DIGIT_OK bit 0, frame still completes.
//  SA=0000 for TIMEOUT (1024) clocks after STABLE=1 -> LOST=1, STABLE=0; next full frame -> FRAME, STABLE stays 0.
//  RESET pulsed after two digits captured -> all outputs at reset values; next 4 strobes yield exactly one FRAME.
//    Repeat with SEG_CAPTURE_SYNC_EN defined: same results, 2 clocks later.

Source files
------------

// File: rtl/seg_scan_capture_pkg.sv
// Shared constants for the multiplexed 7-segment bus: segment bit order,
// digit strobe one-hot codes and the 16-entry hex glyph table. The display
// driver uses the same package, so both ends agree on what a glyph looks like.
package seg_scan_capture_pkg;

    // Segment byte bit positions, byte = {a,b,c,d,e,f,g,dp}
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Digit strobe codes on SA
    localparam logic [3:0] SA_BLANK = 4'b0000;
    localparam logic [3:0] SA_D1    = 4'b0001;
    localparam logic [3:0] SA_D2    = 4'b0010;
    localparam logic [3:0] SA_D3    = 4'b0100;
    localparam logic [3:0] SA_D4    = 4'b1000;
    localparam logic [3:0] SA_ALL   = SA_D4 | SA_D3 | SA_D2 | SA_D1;

    // Glyph for hex value i lives at GLYPH_TABLE[i]; dp bit is always 0
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    typedef struct packed {
        logic       ok;
        logic [3:0] hex;
    } seg_decode_t;

    // Reverse glyph lookup on segments a..g; unknown patterns give {0,0}
    function automatic seg_decode_t glyph_decode(input logic [6:0] seg);
        seg_decode_t r;
        r = '{ok: 1'b0, hex: 4'h0};
        for (int i = 0; i < 16; i++) begin
            if (GLYPH_TABLE[i][SEG_A:SEG_G] == seg) begin
                r.ok  = 1'b1;
                r.hex = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Multiplexed 7-segment bus: one-hot digit strobe SA plus segment byte L.
// master = the display driver side, slave = a receiver such as the capture block.
interface seg_scan_capture_if;
    logic [3:0] SA;
    logic [7:0] L;

    modport master (output SA, L);
    modport slave  (input  SA, L);
endinterface

// File: rtl/seg_scan_capture_seg7_decode.sv
// Combinational segment-pattern to hex decoder (dp excluded from the input).
module seg7_decode
    import seg_scan_capture_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       ok_o,
    output logic [3:0] hex_o
);

    seg_decode_t dec;

    assign dec   = glyph_decode(seg_i);
    assign ok_o  = dec.ok;
    assign hex_o = dec.hex;

endmodule

// File: rtl/seg_scan_capture.sv
// Receive end of the 4-digit multiplexed 7-segment bus. Captures each digit's
// segment byte on the first cycle of its strobe, decodes it back to hex, and
// reports frame completion, multi-frame stability, bus errors and loss of scan.
// Optional build macro SEG_CAPTURE_SYNC_EN: inserts a 2-flop synchroniser on
// SA and L for an asynchronous bus (all latencies grow by 2 clocks).
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT       = 1024
) (
    input  logic               CLK,
    input  logic               RESET,
    seg_scan_capture_if.slave  bus,
    output logic [7:0]         D1,
    output logic [7:0]         D2,
    output logic [7:0]         D3,
    output logic [7:0]         D4,
    output logic [3:0]         HEX1,
    output logic [3:0]         HEX2,
    output logic [3:0]         HEX3,
    output logic [3:0]         HEX4,
    output logic [3:0]         DIGIT_OK,
    output logic               FRAME,
    output logic               STABLE,
    output logic               ERR,
    output logic               LOST
);

    localparam int CNT_W = $clog2(STABLE_FRAMES + 1);
    localparam int TMO_W = $clog2(TIMEOUT);

    // Bus as seen by the edge logic (direct or synchronised)
    logic [3:0] sa_w;
    logic [7:0] l_w;

    logic [3:0]       sa_q;
    logic [3:0][7:0]  d_q,   d_d;
    logic [3:0][3:0]  hex_q, hex_d;
    logic [3:0]       ok_q,  ok_d;
    logic [3:0]       seen_q, seen_d;
    logic [31:0]      snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             frame_q, frame_d;
    logic             err_q;
    logic             lost_q, lost_d;

    logic       multi_hot;
    logic       one_hot;
    logic       strobe_start;
    logic       dec_ok;
    logic [3:0] dec_hex;

    // More than one strobe bit set: clearing the lowest set bit leaves something
    assign multi_hot    = (sa_w & (sa_w - 4'd1)) != 4'd0;
    assign one_hot      = (sa_w != SA_BLANK) && !multi_hot;
    assign strobe_start = one_hot && (sa_w != sa_q);

    seg7_decode u_decode (
        .seg_i (l_w[SEG_A:SEG_G]),
        .ok_o  (dec_ok),
        .hex_o (dec_hex)
    );

    // Next-state: capture on strobe start, frame bookkeeping, scan timeout
    // NOTE: every variable gets a default at the top so no path leaves one unassigned and infers a latch.
    always_comb begin
        d_d     = d_q;
        hex_d   = hex_q;
        ok_d    = ok_q;
        seen_d  = seen_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        lost_d  = lost_q;
        frame_d = 1'b0;

        if (strobe_start) begin
            for (int n = 0; n < 4; n++) begin
                if (sa_w[n]) begin
                    d_d[n]   = l_w;
                    hex_d[n] = dec_hex;
                    ok_d[n]  = dec_ok;
                end
            end
            seen_d = seen_q | sa_w;
            tmo_d  = '0;
            lost_d = 1'b0;

            // Last missing digit arrived: close the frame and compare snapshots
            if (seen_d == SA_ALL) begin
                frame_d = 1'b1;
                seen_d  = '0;
                snap_d  = d_d;
                if (snap_d == snap_q) begin
                    if (cnt_q != CNT_W'(STABLE_FRAMES)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            // Scan stalled: drop the partial frame and the stability history
            lost_d = 1'b1;
            cnt_d  = '0;
            seen_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // State registers
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: the capture registers are plain flops, not a RAM, so they take a reset value like any other state.
            sa_q    <= SA_BLANK;
            d_q     <= '0;
            hex_q   <= '0;
            ok_q    <= '0;
            seen_q  <= '0;
            snap_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b1;
        end else begin
            sa_q    <= sa_w;
            d_q     <= d_d;
            hex_q   <= hex_d;
            ok_q    <= ok_d;
            seen_q  <= seen_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            frame_q <= frame_d;
            err_q   <= multi_hot;
            lost_q  <= lost_d;
        end
    end

`ifdef SEG_CAPTURE_SYNC_EN
    logic [3:0] sa_s1_q, sa_s2_q;
    logic [7:0] l_s1_q,  l_s2_q;

    // Two-stage synchroniser for an asynchronous display bus
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sa_s1_q <= '0;
            sa_s2_q <= '0;
            l_s1_q  <= '0;
            l_s2_q  <= '0;
        end else begin
            sa_s1_q <= bus.SA;
            sa_s2_q <= sa_s1_q;
            l_s1_q  <= bus.L;
            l_s2_q  <= l_s1_q;
        end
    end

    assign sa_w = sa_s2_q;
    assign l_w  = l_s2_q;
`else
    assign sa_w = bus.SA;
    assign l_w  = bus.L;
`endif

    assign D1       = d_q[0];
    assign D2       = d_q[1];
    assign D3       = d_q[2];
    assign D4       = d_q[3];
    assign HEX1     = hex_q[0];
    assign HEX2     = hex_q[1];
    assign HEX3     = hex_q[2];
    assign HEX4     = hex_q[3];
    assign DIGIT_OK = ok_q;
    assign FRAME    = frame_q;
    assign STABLE   = (cnt_q == CNT_W'(STABLE_FRAMES));
    assign ERR      = err_q;
    assign LOST     = lost_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed vector table, hand-written
// corner sequences and randomised traffic against a behavioural model.
module tb_seg_scan_capture;

    localparam int STABLE_FRAMES = 3;
    localparam int TIMEOUT       = 1024;
`ifdef SEG_CAPTURE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] D1, D2, D3, D4;
    logic [3:0] HEX1, HEX2, HEX3, HEX4;
    logic [3:0] DIGIT_OK;
    logic       FRAME, STABLE, ERR, LOST;

    seg_scan_capture_if bus ();

    seg_scan_capture #(
        .STABLE_FRAMES (STABLE_FRAMES),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .bus      (bus.slave),
        .D1       (D1),
        .D2       (D2),
        .D3       (D3),
        .D4       (D4),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .DIGIT_OK (DIGIT_OK),
        .FRAME    (FRAME),
        .STABLE   (STABLE),
        .ERR      (ERR),
        .LOST     (LOST)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_frames = 0;

    logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                   8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [3:0]  m_prev_sa;
    bit [3:0]  m_seen;
    bit [7:0]  m_cap [4];
    bit [3:0]  m_hex [4];
    bit        m_ok  [4];
    bit        m_frame, m_err, m_lost;
    int        m_idle;
    bit [31:0] m_hist [$];
    bit [3:0]  m_psa [2];
    bit [7:0]  m_pl  [2];

    function automatic bit [4:0] ref_decode(input bit [7:0] b);
        case (b & 8'hFE)
            8'hFC: return {1'b1, 4'h0};  8'h60: return {1'b1, 4'h1};
            8'hDA: return {1'b1, 4'h2};  8'hF2: return {1'b1, 4'h3};
            8'h66: return {1'b1, 4'h4};  8'hB6: return {1'b1, 4'h5};
            8'hBE: return {1'b1, 4'h6};  8'hE0: return {1'b1, 4'h7};
            8'hFE: return {1'b1, 4'h8};  8'hF6: return {1'b1, 4'h9};
            8'hEE: return {1'b1, 4'hA};  8'h3E: return {1'b1, 4'hB};
            8'h9C: return {1'b1, 4'hC};  8'h7A: return {1'b1, 4'hD};
            8'h9E: return {1'b1, 4'hE};  8'h8E: return {1'b1, 4'hF};
            default: return 5'b0;
        endcase
    endfunction

    function automatic void model_reset();
        m_prev_sa = '0; m_seen = '0; m_frame = 0; m_err = 0; m_lost = 1; m_idle = 0;
        m_hist.delete();
        for (int n = 0; n < 4; n++) begin
            m_cap[n] = '0; m_hex[n] = '0; m_ok[n] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            m_psa[k] = '0; m_pl[k] = '0;
        end
    endfunction

    function automatic void model_edge(input bit [3:0] sa_in, input bit [7:0] l_in);
        bit [3:0] sa;
        bit [7:0] l;
        if (SYNC != 0) begin
            sa = m_psa[1]; l = m_pl[1];
            m_psa[1] = m_psa[0]; m_pl[1] = m_pl[0];
            m_psa[0] = sa_in;    m_pl[0] = l_in;
        end else begin
            sa = sa_in; l = l_in;
        end
        m_frame = 0;
        m_err   = ($countones(sa) > 1);
        if ($countones(sa) == 1 && sa != m_prev_sa) begin
            for (int n = 0; n < 4; n++) begin
                if (sa[n]) begin
                    m_cap[n] = l;
                    {m_ok[n], m_hex[n]} = ref_decode(l);
                end
            end
            m_seen |= sa;
            m_idle  = 0;
            m_lost  = 0;
            if (m_seen == 4'hF) begin
                m_frame = 1;
                m_seen  = '0;
                m_hist.push_back({m_cap[3], m_cap[2], m_cap[1], m_cap[0]});
                if (m_hist.size() > STABLE_FRAMES) void'(m_hist.pop_front());
            end
        end else begin
            if (m_idle < TIMEOUT) m_idle++;
            if (m_idle >= TIMEOUT) begin
                m_lost = 1;
                m_seen = '0;
                m_hist.delete();
            end
        end
        m_prev_sa = sa;
    endfunction

    // Stable when the retained history holds STABLE_FRAMES identical frames
    function automatic bit model_stable();
        if (m_hist.size() < STABLE_FRAMES) return 0;
        foreach (m_hist[i]) if (m_hist[i] != m_hist[m_hist.size()-1]) return 0;
        return 1;
    endfunction

    task automatic compare_model();
        check("model_d",      {D4, D3, D2, D1}, {m_cap[3], m_cap[2], m_cap[1], m_cap[0]});
        check("model_hex",    32'({HEX4, HEX3, HEX2, HEX1}), 32'({m_hex[3], m_hex[2], m_hex[1], m_hex[0]}));
        check("model_ok",     32'(DIGIT_OK), 32'({m_ok[3], m_ok[2], m_ok[1], m_ok[0]}));
        check("model_frame",  32'(FRAME),  32'(m_frame));
        check("model_stable", 32'(STABLE), 32'(model_stable()));
        check("model_err",    32'(ERR),    32'(m_err));
        check("model_lost",   32'(LOST),   32'(m_lost));
    endtask

    // One clock: drive, wait for the edge, sample 1 time unit later
    task automatic step(input logic [3:0] sa, input logic [7:0] l);
        bus.SA = sa;
        bus.L  = l;
        @(posedge CLK);
        #1;
        model_edge(sa, l);
        compare_model();
        if (FRAME) n_frames++;
    endtask

    // Hold a bus value long enough for it to reach the outputs
    task automatic hold(input logic [3:0] sa, input logic [7:0] l);
        for (int k = 0; k < 1 + SYNC; k++) step(sa, l);
    endtask

    task automatic send_frame(input logic [7:0] l4, input logic [7:0] l3,
                              input logic [7:0] l2, input logic [7:0] l1);
        hold(4'b1000, l4); hold(4'b0000, 8'h00);
        hold(4'b0100, l3); hold(4'b0000, 8'h00);
        hold(4'b0010, l2); hold(4'b0000, 8'h00);
        hold(4'b0001, l1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_d"},      {D4, D3, D2, D1}, 32'h0);
        check({tag, "_hex"},    32'({HEX4, HEX3, HEX2, HEX1}), 32'h0);
        check({tag, "_ok"},     32'(DIGIT_OK), 32'h0);
        check({tag, "_frame"},  32'(FRAME),  32'h0);
        check({tag, "_stable"}, 32'(STABLE), 32'h0);
        check({tag, "_err"},    32'(ERR),    32'h0);
        check({tag, "_lost"},   32'(LOST),   32'h1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  sa;
        logic [7:0]  l;
        logic [31:0] d;
        logic [15:0] hex;
        logic [3:0]  ok;
        logic        frame, stable, lost, err;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(input logic [3:0] sa, input logic [7:0] l, input logic [31:0] d,
                                input logic [15:0] hex, input logic [3:0] ok,
                                input logic frame, input logic stable, input logic lost, input logic err);
        vec_t v;
        v = '{sa: sa, l: l, d: d, hex: hex, ok: ok, frame: frame, stable: stable, lost: lost, err: err};
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] r_sa;
        logic [7:0] r_l;

        // frame 1
        add(4'b1000, 8'h60, 32'h6000_0000, 16'h1000, 4'b1000, 0, 0, 0, 0);
        add(4'b0000, 8'h00, 32'h6000_0000, 16'h1000, 4'b1000, 0, 0, 0, 0);
        add(4'b0100, 8'hDA, 32'h60DA_0000, 16'h1200, 4'b1100, 0, 0, 0, 0);
        add(4'b0000, 8'h00, 32'h60DA_0000, 16'h1200, 4'b1100, 0, 0, 0, 0);
        add(4'b0010, 8'hF2, 32'h60DA_F200, 16'h1230, 4'b1110, 0, 0, 0, 0);
        add(4'b0000, 8'h00, 32'h60DA_F200, 16'h1230, 4'b1110, 0, 0, 0, 0);
        add(4'b0001, 8'h66, 32'h60DA_F266, 16'h1234, 4'b1111, 1, 0, 0, 0);
        add(4'b0000, 8'h00, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 0, 0, 0);
        // frames 2 and 3 repeat it; STABLE rises with the third FRAME
        for (int f = 2; f <= 3; f++) begin
            add(4'b1000, 8'h60, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 0, 0, 0);
            add(4'b0000, 8'h00, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 0, 0, 0);
            add(4'b0100, 8'hDA, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 0, 0, 0);
            add(4'b0000, 8'h00, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 0, 0, 0);
            add(4'b0010, 8'hF2, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 0, 0, 0);
            add(4'b0000, 8'h00, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 0, 0, 0);
            add(4'b0001, 8'h66, 32'h60DA_F266, 16'h1234, 4'b1111, 1, (f == 3), 0, 0);
            add(4'b0000, 8'h00, 32'h60DA_F266, 16'h1234, 4'b1111, 0, (f == 3), 0, 0);
        end
        // frame 4 changes D1 to 5: STABLE drops with that FRAME
        add(4'b1000, 8'h60, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 1, 0, 0);
        add(4'b0000, 8'h00, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 1, 0, 0);
        add(4'b0100, 8'hDA, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 1, 0, 0);
        add(4'b0000, 8'h00, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 1, 0, 0);
        add(4'b0010, 8'hF2, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 1, 0, 0);
        add(4'b0000, 8'h00, 32'h60DA_F266, 16'h1234, 4'b1111, 0, 1, 0, 0);
        add(4'b0001, 8'hB6, 32'h60DA_F2B6, 16'h1235, 4'b1111, 1, 0, 0, 0);
        add(4'b0000, 8'h00, 32'h60DA_F2B6, 16'h1235, 4'b1111, 0, 0, 0, 0);
        // two strobe bits at once: ERR only, nothing captured
        add(4'b0101, 8'h77, 32'h60DA_F2B6, 16'h1235, 4'b1111, 0, 0, 0, 1);
        add(4'b0000, 8'h00, 32'h60DA_F2B6, 16'h1235, 4'b1111, 0, 0, 0, 0);

        // reset state
        bus.SA = 4'b0000;
        bus.L  = 8'h00;
        #22;
        check_reset_values("reset");
        RESET = 1'b0;
        model_reset();

        foreach (vecs[i]) begin
            hold(vecs[i].sa, vecs[i].l);
            check($sformatf("vec%0d_d", i),      {D4, D3, D2, D1}, vecs[i].d);
            check($sformatf("vec%0d_hex", i),    32'({HEX4, HEX3, HEX2, HEX1}), 32'(vecs[i].hex));
            check($sformatf("vec%0d_ok", i),     32'(DIGIT_OK), 32'(vecs[i].ok));
            check($sformatf("vec%0d_frame", i),  32'(FRAME),  32'(vecs[i].frame));
            check($sformatf("vec%0d_stable", i), 32'(STABLE), 32'(vecs[i].stable));
            check($sformatf("vec%0d_lost", i),   32'(LOST),   32'(vecs[i].lost));
            check($sformatf("vec%0d_err", i),    32'(ERR),    32'(vecs[i].err));
        end

        // strobe held 5 cycles while L changes: only the first byte is taken
        step(4'b0010, 8'hDA);
        step(4'b0010, 8'hF2);
        step(4'b0010, 8'h66);
        step(4'b0010, 8'hB6);
        step(4'b0010, 8'hFC);
        for (int k = 0; k < SYNC; k++) step(4'b0010, 8'h9E);
        check("hold_d2",   32'(D2),   32'h0000_00DA);
        check("hold_hex2", 32'(HEX2), 32'h2);
        hold(4'b0000, 8'h00);

        // non-glyph bytes decode to 0 / not OK, yet the frame completes
        hold(4'b1000, 8'h01); hold(4'b0000, 8'h00);
        hold(4'b0100, 8'h00); hold(4'b0000, 8'h00);
        hold(4'b0001, 8'hFC);
        check("glyph_frame", 32'(FRAME), 32'h1);
        check("glyph_d",     {D4, D3, D2, D1}, 32'h0100_DAFC);
        check("glyph_hex",   32'({HEX4, HEX3, HEX2, HEX1}), 32'h0020);
        check("glyph_ok",    32'(DIGIT_OK), 32'b0011);
        hold(4'b0000, 8'h00);

        // stable, then let the scan stop for TIMEOUT clocks
        for (int f = 0; f < 3; f++) send_frame(8'hFC, 8'h60, 8'hDA, 8'hF2);
        check("tmo_pre_stable", 32'(STABLE), 32'h1);
        for (int k = 0; k < TIMEOUT - 1; k++) step(4'b0000, 8'h00);
        check("tmo_edge_lost",   32'(LOST),   32'h0);
        check("tmo_edge_stable", 32'(STABLE), 32'h1);
        step(4'b0000, 8'h00);
        check("tmo_lost",   32'(LOST),   32'h1);
        check("tmo_stable", 32'(STABLE), 32'h0);
        check("tmo_d_kept", {D4, D3, D2, D1}, 32'hFC60_DAF2);
        send_frame(8'hFC, 8'h60, 8'hDA, 8'hF2);
        check("tmo_next_frame",  32'(FRAME),  32'h1);
        check("tmo_next_stable", 32'(STABLE), 32'h0);
        check("tmo_next_lost",   32'(LOST),   32'h0);
        hold(4'b0000, 8'h00);

        // reset in the middle of a frame discards the partial frame
        hold(4'b1000, 8'h60); hold(4'b0000, 8'h00);
        hold(4'b0100, 8'hDA);
        RESET = 1'b1;
        #2;
        check_reset_values("midreset");
        bus.SA = 4'b0000;
        bus.L  = 8'h00;
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        model_reset();
        n_frames = 0;
        hold(4'b0010, 8'hF2); hold(4'b0000, 8'h00);
        hold(4'b0001, 8'h66); hold(4'b0000, 8'h00);
        check("midreset_no_early_frame", 32'(n_frames), 32'd0);
        hold(4'b1000, 8'h60); hold(4'b0000, 8'h00);
        hold(4'b0100, 8'hDA); hold(4'b0000, 8'h00);
        hold(4'b0000, 8'h00);
        check("midreset_one_frame", 32'(n_frames), 32'd1);

        // randomised traffic against the model
        r_sa = 4'b0000;
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: r_sa = 4'b0000;
                4, 5, 6, 7: r_sa = 4'b0001 << $urandom_range(0, 3);
                8: begin
                    r_sa = 4'($urandom_range(3, 15));
                    if ($countones(r_sa) < 2) r_sa = 4'b1111;
                end
                default: ;
            endcase
            if ($urandom_range(0, 9) < 7)
                r_l = glyph_tab[$urandom_range(0, 15)] | 8'($urandom_range(0, 1));
            else
                r_l = 8'($urandom);
            step(r_sa, r_l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
